mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage front end that sits directly upstream of DataMemory and drives its Address/WriteData/MemWrite/MemRead.
- Converts pipeline load/store requests of byte, halfword or word size into word-aligned DataMemory accesses.
- Performs read-modify-write for sub-word stores, and lane extraction plus sign/zero extension for loads.
- Registers load results toward the MEM/WB stage and stalls the pipeline during RMW.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, word width (fixed at 32; 4 byte lanes)

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
ReqValid  in  1  request present this cycle
ReqRead  in  1  load request
ReqWrite  in  1  store request
ReqSize  in  2  00 byte, 01 half, 10 word, 11 reserved
ReqUnsigned  in  1  1 = zero-extend load (lbu/lhu)
ReqAddr  in  32  byte address
ReqWData  in  32  store data, right-justified
Stall  out  1  hold pipeline; upstream keeps request stable
RespValid  out  1  RespData valid (one-cycle pulse)
RespData  out  32  extended load result
Misaligned  out  1  alignment/size fault pulse
MemAddress  out  32  to DataMemory Address
MemWriteData  out  32  to DataMemory WriteData
MemWrite  out  1  to DataMemory MemWrite
MemRead  out  1  to DataMemory MemRead
MemReadData  in  32  from DataMemory ReadData (combinational)

Behaviour:
- One clock (Clk, rising edge); reset is asynchronous and active-low (Reset_n).
- Reset values: state=IDLE, RespValid=0, RespData=0, Misaligned=0, merge register=0. Memory-side outputs are combinational and read 0 while in reset.
- Lane mapping is little-endian: byte k = bits [8k+7:8k], selected by ReqAddr[1:0]. Halfword lane is ReqAddr[1].
- MemAddress = {ReqAddr[31:2],2'b00} whenever a memory access is driven. Otherwise it is 0.
- Fault detection (IDLE, ReqValid=1):
  - Half with ReqAddr[0]=1, word with ReqAddr[1:0]!=0, or ReqSize=11 is a fault.
  - On a fault: no MemRead/MemWrite; Misaligned=1 next cycle for one cycle; RespValid stays 0; no stall.
- ReqRead=1 and ReqWrite=1 together: the write is performed and the read is ignored.
- ReqValid=0 or neither Read nor Write: the request is ignored.
- FSM states: IDLE, RMW_WR.
- Load (IDLE):
  - MemRead=1 this cycle.
  - Next edge: RespValid=1 and RespData=extracted lane. Extension is sign-extend unless ReqUnsigned=1. Word loads are unmodified.
  - Latency 1, no stall. Back-to-back loads every cycle are legal.
- Word store (IDLE): MemWrite=1 and MemWriteData=ReqWData this cycle; the write commits at the edge. No stall, no response.
- Sub-word store:
  - IDLE cycle: MemRead=1 and Stall=1. Merge register <= MemReadData with the target lane replaced by ReqWData[7:0] or [15:0]. Go to RMW_WR.
  - RMW_WR cycle: MemWrite=1, MemWriteData=merge register, MemRead=0, Stall=0. Return to IDLE at the edge; the request is consumed.
  - Upstream advances only after RMW_WR. Total 2 cycles.
- In RMW_WR the request inputs are not re-evaluated (no double accept).
- RespValid and Misaligned are deasserted every cycle they are not set (pulses).
- Reset asserted mid-RMW: return to IDLE immediately. The pending write is abandoned; no MemWrite in the cycle after release.
- Reset asserted with a load outstanding: the response is dropped (RespValid=0).

Test Plan:
- Reset then word store: after Reset_n low→high, RespValid=0, Misaligned=0. Store word 0xDEADBEEF @0x10 -> MemWrite=1, MemAddress=0x10 one cycle; later word load @0x10 -> RespData=0xDEADBEEF, RespValid high exactly the cycle after.
- Byte loads: mem[0x10]=0x80FF7F01. lb @0x13 -> 0xFFFFFF80. lbu @0x13 -> 0x00000080. lb @0x11 -> 0x0000007F. lh @0x12 -> 0xFFFF80FF.
- Byte store RMW: mem[0x20]=0x11223344, sb 0xAA @0x21 -> Stall=1 one cycle (MemRead=1), then MemWrite=1 with 0x1122AA44, Stall=0; subsequent lw @0x20 returns 0x1122AA44.
- Halfword store RMW: sh 0xBEEF @0x22 on 0x11223344 -> written 0xBEEF3344; two cycles total.
- Faults: lh @0x21, lw @0x22, sw @0x23, ReqSize=11 -> each gives one Misaligned pulse, MemRead=MemWrite=0, memory unchanged, RespValid=0.
- Reset mid-RMW: sb issued, assert Reset_n=0 during RMW_WR -> no MemWrite, memory word unchanged, FSM in IDLE. Next load after release is serviced normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and DataMemory port bundle for mem_access_unit.
interface mem_access_unit_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   // pipeline request side
   logic              ReqValid;
   logic              ReqRead;
   logic              ReqWrite;
   logic [1:0]        ReqSize;
   logic              ReqUnsigned;
   logic [ADDR_W-1:0] ReqAddr;
   logic [DATA_W-1:0] ReqWData;
   logic              Stall;
   logic              RespValid;
   logic [DATA_W-1:0] RespData;
   logic              Misaligned;

   // DataMemory side
   logic [ADDR_W-1:0] MemAddress;
   logic [DATA_W-1:0] MemWriteData;
   logic              MemWrite;
   logic              MemRead;
   logic [DATA_W-1:0] MemReadData;

   // unit under the pipeline/memory (the access unit itself)
   modport slave (
      input  ReqValid, ReqRead, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData,
      input  MemReadData,
      output Stall, RespValid, RespData, Misaligned,
      output MemAddress, MemWriteData, MemWrite, MemRead
   );

   // pipeline plus DataMemory driving the unit
   modport master (
      output ReqValid, ReqRead, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData,
      output MemReadData,
      input  Stall, RespValid, RespData, Misaligned,
      input  MemAddress, MemWriteData, MemWrite, MemRead
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage front end: sub-word loads/stores mapped onto word-wide DataMemory.
module mem_access_unit (
   input  logic              Clk,
   input  logic              Reset_n,
   mem_access_unit_if.slave  bus
);
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_RMW_WR = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              misaligned_q, misaligned_d;
   logic [DATA_W-1:0] merge_q, merge_d;

   logic              stall_c, mem_read_c, mem_write_c;
   logic [ADDR_W-1:0] mem_address_c;
   logic [DATA_W-1:0] mem_wdata_c;

   logic [1:0]        lane;
   logic [ADDR_W-1:0] word_addr;
   logic              req_active, req_fault, size_word;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] load_ext;
   logic [DATA_W-1:0] merge_word;

   assign lane      = bus.ReqAddr[1:0];
   assign word_addr = {bus.ReqAddr[ADDR_W-1:2], 2'b00};
   assign size_word = (bus.ReqSize == 2'b10);

   // request qualification and alignment fault detection
   always_comb begin
      req_active = bus.ReqValid & (bus.ReqRead | bus.ReqWrite);
      case (bus.ReqSize)
         2'b00:   req_fault = 1'b0;
         2'b01:   req_fault = lane[0];
         2'b10:   req_fault = (lane != 2'b00);
         default: req_fault = 1'b1;
      endcase
   end

   // load lane extraction with sign/zero extension
   always_comb begin
      byte_sel = bus.MemReadData[{lane, 3'b000} +: 8];
      half_sel = bus.MemReadData[{lane[1], 4'b0000} +: 16];
      case (bus.ReqSize)
         2'b00:   load_ext = {{24{byte_sel[7] & ~bus.ReqUnsigned}}, byte_sel};
         2'b01:   load_ext = {{16{half_sel[15] & ~bus.ReqUnsigned}}, half_sel};
         default: load_ext = bus.MemReadData;
      endcase
   end

   // store data merged into the word read back from memory
   always_comb begin
      merge_word = bus.MemReadData;
      if (bus.ReqSize == 2'b00)
         merge_word[{lane, 3'b000} +: 8] = bus.ReqWData[7:0];
      else
         merge_word[{lane[1], 4'b0000} +: 16] = bus.ReqWData[15:0];
   end

   // next state and memory-side control; memory port idles while in reset
   always_comb begin
      state_d       = state_q;
      resp_valid_d  = 1'b0;
      resp_data_d   = resp_data_q;
      misaligned_d  = 1'b0;
      merge_d       = merge_q;
      stall_c       = 1'b0;
      mem_read_c    = 1'b0;
      mem_write_c   = 1'b0;
      mem_address_c = '0;
      mem_wdata_c   = '0;
      if (Reset_n) begin
         case (state_q)
            ST_IDLE: begin
               if (req_active && req_fault) begin
                  misaligned_d = 1'b1;
               end else if (req_active && bus.ReqWrite) begin
                  mem_address_c = word_addr;
                  if (size_word) begin
                     mem_write_c = 1'b1;
                     mem_wdata_c = bus.ReqWData;
                  end else begin
                     mem_read_c = 1'b1;
                     stall_c    = 1'b1;
                     merge_d    = merge_word;
                     state_d    = ST_RMW_WR;
                  end
               end else if (req_active) begin
                  mem_address_c = word_addr;
                  mem_read_c    = 1'b1;
                  resp_valid_d  = 1'b1;
                  resp_data_d   = load_ext;
               end
            end
            ST_RMW_WR: begin
               // request is held stable upstream; only the write half is issued
               mem_address_c = word_addr;
               mem_write_c   = 1'b1;
               mem_wdata_c   = merge_q;
               state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // state, response and merge registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= ST_IDLE;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         misaligned_q <= 1'b0;
         merge_q      <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         misaligned_q <= misaligned_d;
         merge_q      <= merge_d;
      end
   end

   assign bus.Stall        = stall_c;
   assign bus.RespValid    = resp_valid_q;
   assign bus.RespData     = resp_data_q;
   assign bus.Misaligned   = misaligned_q;
   assign bus.MemAddress   = mem_address_c;
   assign bus.MemWriteData = mem_wdata_c;
   assign bus.MemWrite     = mem_write_c;
   assign bus.MemRead      = mem_read_c;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner sequences, random traffic.
module tb_mem_access_unit;
   localparam int K_NONE = 0;
   localparam int K_LD   = 1;
   localparam int K_SW   = 2;
   localparam int K_RMW  = 3;
   localparam int K_FLT  = 4;

   typedef struct {
      string       name;
      logic        vld, rd, wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr, wdata;
      int          kind;
      logic [31:0] data;   // load result, or word written to memory for stores
   } vec_t;

   logic Clk;
   logic Reset_n;
   int   checks;
   int   failures;

   logic [31:0] dmem    [0:63];
   logic [31:0] ref_mem [0:63];

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   // DataMemory stand-in: combinational read, write on the rising edge
   assign bus.MemReadData = dmem[bus.MemAddress[7:2]];
   always @(posedge Clk) if (bus.MemWrite) dmem[bus.MemAddress[7:2]] <= bus.MemWriteData;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, 32'(act), 32'(exp));
   endtask

   function automatic vec_t mk(input string nm, input logic vld, input logic rd, input logic wr,
                               input logic [1:0] size, input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input int kind, input logic [31:0] data);
      vec_t v;
      v.name = nm; v.vld = vld; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
      v.addr = addr; v.wdata = wdata; v.kind = kind; v.data = data;
      return v;
   endfunction

   // reference rules expressed with masks and shifts
   function automatic logic ref_fault(input logic [1:0] size, input logic [31:0] addr);
      return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] size,
                                             input int off, input logic [31:0] wdata);
      logic [31:0] mask;
      if (size == 2'd2) return wdata;
      mask = ((size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
      return (old & ~mask) | ((wdata << (8 * off)) & mask);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                            input int off, input logic uns);
      logic [31:0] v;
      v = word >> (8 * off);
      if (size == 2'd0) begin
         v = v & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
         v = v & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic vec_t model_vec(input string nm, input logic vld, input logic rd, input logic wr,
                                      input logic [1:0] size, input logic uns,
                                      input logic [31:0] addr, input logic [31:0] wdata);
      int          kind;
      logic [31:0] data;
      int          off;
      off  = int'(addr[1:0]);
      kind = K_NONE;
      data = 32'h0;
      if (vld && (rd || wr)) begin
         if (ref_fault(size, addr)) kind = K_FLT;
         else if (wr) begin
            kind = (size == 2'd2) ? K_SW : K_RMW;
            data = ref_store(ref_mem[addr[7:2]], size, off, wdata);
         end else begin
            kind = K_LD;
            data = ref_load(ref_mem[addr[7:2]], size, off, uns);
         end
      end
      return mk(nm, vld, rd, wr, size, uns, addr, wdata, kind, data);
   endfunction

   task automatic drive(input vec_t v);
      bus.ReqValid = v.vld; bus.ReqRead = v.rd; bus.ReqWrite = v.wr; bus.ReqSize = v.size;
      bus.ReqUnsigned = v.uns; bus.ReqAddr = v.addr; bus.ReqWData = v.wdata;
   endtask

   // apply one request and check every cycle it occupies
   task automatic run(input vec_t v);
      logic        ld, st, sw, rmw, flt;
      logic [31:0] al;
      ld  = (v.kind == K_LD);
      sw  = (v.kind == K_SW);
      rmw = (v.kind == K_RMW);
      flt = (v.kind == K_FLT);
      st  = sw || rmw;
      al  = {v.addr[31:2], 2'b00};
      @(negedge Clk);
      drive(v);
      #1;
      chk1({v.name, " stall"}, bus.Stall, rmw);
      chk1({v.name, " memrd"}, bus.MemRead, ld || rmw);
      chk1({v.name, " memwr"}, bus.MemWrite, sw);
      chk({v.name, " maddr"}, bus.MemAddress, (ld || st) ? al : 32'h0);
      if (sw) chk({v.name, " mwdata"}, bus.MemWriteData, v.data);
      @(posedge Clk);
      #1;
      chk1({v.name, " misal"}, bus.Misaligned, flt);
      chk1({v.name, " rvalid"}, bus.RespValid, ld);
      if (ld) chk({v.name, " rdata"}, bus.RespData, v.data);
      if (rmw) begin
         @(negedge Clk);
         #1;
         chk1({v.name, " wr stall"}, bus.Stall, 1'b0);
         chk1({v.name, " wr memrd"}, bus.MemRead, 1'b0);
         chk1({v.name, " wr memwr"}, bus.MemWrite, 1'b1);
         chk({v.name, " wr maddr"}, bus.MemAddress, al);
         chk({v.name, " wr mwdata"}, bus.MemWriteData, v.data);
         @(posedge Clk);
         #1;
         chk1({v.name, " wr rvalid"}, bus.RespValid, 1'b0);
         chk1({v.name, " wr misal"}, bus.Misaligned, 1'b0);
      end
      if (st) ref_mem[v.addr[7:2]] = v.data;
   endtask

   vec_t tbl[$];

   initial begin
      checks = 0;
      failures = 0;
      Reset_n = 1'b0;
      drive(mk("rst", 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, K_NONE, 32'h0));

      // memory port must stay quiet during reset even with a request present
      #3;
      chk1("reset memrd", bus.MemRead, 1'b0);
      chk1("reset memwr", bus.MemWrite, 1'b0);
      chk("reset maddr", bus.MemAddress, 32'h0);
      chk1("reset stall", bus.Stall, 1'b0);
      chk1("reset rvalid", bus.RespValid, 1'b0);
      chk1("reset misal", bus.Misaligned, 1'b0);
      chk("reset rdata", bus.RespData, 32'h0);
      @(negedge Clk);
      bus.ReqValid = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;
      chk1("post-reset rvalid", bus.RespValid, 1'b0);
      chk1("post-reset misal", bus.Misaligned, 1'b0);

      tbl.push_back(mk("sw deadbeef",  1, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, K_SW,  32'hDEADBEEF));
      tbl.push_back(mk("lw 10",        1, 1, 0, 2'd2, 0, 32'h10, 32'h0,        K_LD,  32'hDEADBEEF));
      tbl.push_back(mk("sw 80ff7f01",  1, 0, 1, 2'd2, 0, 32'h10, 32'h80FF7F01, K_SW,  32'h80FF7F01));
      tbl.push_back(mk("lb 13",        1, 1, 0, 2'd0, 0, 32'h13, 32'h0,        K_LD,  32'hFFFFFF80));
      tbl.push_back(mk("lbu 13",       1, 1, 0, 2'd0, 1, 32'h13, 32'h0,        K_LD,  32'h00000080));
      tbl.push_back(mk("lb 11",        1, 1, 0, 2'd0, 0, 32'h11, 32'h0,        K_LD,  32'h0000007F));
      tbl.push_back(mk("lb 10",        1, 1, 0, 2'd0, 0, 32'h10, 32'h0,        K_LD,  32'h00000001));
      tbl.push_back(mk("lh 12",        1, 1, 0, 2'd1, 0, 32'h12, 32'h0,        K_LD,  32'hFFFF80FF));
      tbl.push_back(mk("lhu 12",       1, 1, 0, 2'd1, 1, 32'h12, 32'h0,        K_LD,  32'h000080FF));
      tbl.push_back(mk("sw 11223344",  1, 0, 1, 2'd2, 0, 32'h20, 32'h11223344, K_SW,  32'h11223344));
      tbl.push_back(mk("sb aa 21",     1, 0, 1, 2'd0, 0, 32'h21, 32'h123456AA, K_RMW, 32'h1122AA44));
      tbl.push_back(mk("lw 20 sb",     1, 1, 0, 2'd2, 0, 32'h20, 32'h0,        K_LD,  32'h1122AA44));
      tbl.push_back(mk("sw 11223344b", 1, 0, 1, 2'd2, 0, 32'h20, 32'h11223344, K_SW,  32'h11223344));
      tbl.push_back(mk("sh beef 22",   1, 0, 1, 2'd1, 0, 32'h22, 32'hCAFEBEEF, K_RMW, 32'hBEEF3344));
      tbl.push_back(mk("lw 20 sh",     1, 1, 0, 2'd2, 0, 32'h20, 32'h0,        K_LD,  32'hBEEF3344));
      tbl.push_back(mk("lh 21 flt",    1, 1, 0, 2'd1, 0, 32'h21, 32'h0,        K_FLT, 32'h0));
      tbl.push_back(mk("lw 22 flt",    1, 1, 0, 2'd2, 0, 32'h22, 32'h0,        K_FLT, 32'h0));
      tbl.push_back(mk("sw 23 flt",    1, 0, 1, 2'd2, 0, 32'h23, 32'h01020304, K_FLT, 32'h0));
      tbl.push_back(mk("size3 flt",    1, 1, 0, 2'd3, 0, 32'h20, 32'h0,        K_FLT, 32'h0));
      tbl.push_back(mk("sh 21 flt",    1, 0, 1, 2'd1, 0, 32'h21, 32'h5555,     K_FLT, 32'h0));
      tbl.push_back(mk("lw 20 after",  1, 1, 0, 2'd2, 0, 32'h20, 32'h0,        K_LD,  32'hBEEF3344));
      tbl.push_back(mk("rd+wr sw 30",  1, 1, 1, 2'd2, 0, 32'h30, 32'h55667788, K_SW,  32'h55667788));
      tbl.push_back(mk("invalid wr",   0, 0, 1, 2'd2, 0, 32'h30, 32'h0,        K_NONE, 32'h0));
      tbl.push_back(mk("no rd no wr",  1, 0, 0, 2'd1, 0, 32'h31, 32'h0,        K_NONE, 32'h0));
      tbl.push_back(mk("lw 30",        1, 1, 0, 2'd2, 0, 32'h30, 32'h0,        K_LD,  32'h55667788));
      tbl.push_back(mk("sb 99 33",     1, 0, 1, 2'd0, 0, 32'h33, 32'h00000099, K_RMW, 32'h99667788));
      tbl.push_back(mk("sh 1234 30",   1, 0, 1, 2'd1, 0, 32'h30, 32'hFFFF1234, K_RMW, 32'h99661234));
      tbl.push_back(mk("lh 30",        1, 1, 0, 2'd1, 0, 32'h30, 32'h0,        K_LD,  32'h00001234));
      tbl.push_back(mk("lh 32",        1, 1, 0, 2'd1, 0, 32'h32, 32'h0,        K_LD,  32'hFFFF9966));
      foreach (tbl[i]) run(tbl[i]);

      // reset during the write half of a read-modify-write
      @(negedge Clk);
      drive(mk("rmw rst", 1, 0, 1, 2'd0, 0, 32'h20, 32'h77, K_RMW, 32'h0));
      #1;
      chk1("rmwrst idle stall", bus.Stall, 1'b1);
      @(posedge Clk);
      @(negedge Clk);
      #1;
      chk1("rmwrst in wr memwr", bus.MemWrite, 1'b1);
      Reset_n = 1'b0;
      bus.ReqValid = 1'b0;
      #1;
      chk1("rmwrst during memwr", bus.MemWrite, 1'b0);
      @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      chk1("rmwrst release memwr", bus.MemWrite, 1'b0);
      chk1("rmwrst release stall", bus.Stall, 1'b0);
      @(posedge Clk);
      #1;
      chk1("rmwrst rvalid", bus.RespValid, 1'b0);
      run(mk("lw 20 rmwrst", 1, 1, 0, 2'd2, 0, 32'h20, 32'h0, K_LD, 32'hBEEF3344));

      // reset with a load response pending
      @(negedge Clk);
      drive(mk("ld rst", 1, 1, 0, 2'd2, 0, 32'h10, 32'h0, K_LD, 32'h0));
      @(posedge Clk);
      #1;
      chk1("ldrst rvalid before", bus.RespValid, 1'b1);
      Reset_n = 1'b0;
      bus.ReqValid = 1'b0;
      #1;
      chk1("ldrst rvalid dropped", bus.RespValid, 1'b0);
      chk("ldrst rdata cleared", bus.RespData, 32'h0);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;
      chk1("ldrst after release", bus.RespValid, 1'b0);

      // random traffic over a small window checked against the reference rules
      for (int i = 0; i < 8; i++)
         run(model_vec("rinit", 1, 0, 1, 2'd2, 0, 32'h40 + 32'(4 * i), $urandom));
      for (int i = 0; i < 300; i++) begin
         logic        vld, rd, wr, uns;
         logic [1:0]  size;
         logic [31:0] addr;
         vld  = ($urandom_range(0, 9) != 0);
         rd   = 1'($urandom_range(0, 1));
         wr   = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         uns  = 1'($urandom_range(0, 1));
         addr = 32'h40 + 32'($urandom_range(0, 31));
         run(model_vec($sformatf("rnd%0d", i), vld, rd, wr, size, uns, addr, $urandom));
      end

      for (int i = 16; i < 24; i++) chk($sformatf("mem word %0d", i), dmem[i], ref_mem[i]);
      chk("mem word 4", dmem[4], ref_mem[4]);
      chk("mem word 8", dmem[8], ref_mem[8]);
      chk("mem word 12", dmem[12], ref_mem[12]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
